pwm_duty_scheduler: RTL

Slew-limited duty-cycle scheduler that sits between the Nios II register bus and the 9-channel PWM generator. Software writes per-channel target duties, a global step size and an enable. The block sequences one channel per cycle through a ramp calculator. It applies all nine new duty values simultaneously at the PWM period wrap, so no channel ever sees a mid-period duty change.

---
 rtl/pwm_duty_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pwm_duty_scheduler.sv
//==============================================================================
// Module   : pwm_duty_scheduler
// Purpose  : Slew-limited scheduler that ramps nine PWM duties one channel per
//            cycle and applies all of them together at the PWM period wrap.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pwm_duty_scheduler #(
    parameter int RESOLUTION = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [3:0]            wr_addr,
    input  logic [RESOLUTION-1:0] wr_data,
    output logic [RESOLUTION-1:0] duty0,
    output logic [RESOLUTION-1:0] duty1,
    output logic [RESOLUTION-1:0] duty2,
    output logic [RESOLUTION-1:0] duty3,
    output logic [RESOLUTION-1:0] duty4,
    output logic [RESOLUTION-1:0] duty5,
    output logic [RESOLUTION-1:0] duty6,
    output logic [RESOLUTION-1:0] duty7,
    output logic [RESOLUTION-1:0] duty8,
    output logic                  period_tick,
    output logic                  busy
);

    localparam int                    C_NCH        = 9;
    localparam logic [RESOLUTION-1:0] C_MAX        = {RESOLUTION{1'b1}};
    localparam logic [RESOLUTION-1:0] C_CALC_ENTRY = C_MAX - RESOLUTION'(10);
    localparam logic [3:0]            C_LAST_CH    = 4'd8;
    localparam logic [3:0]            C_ADDR_STEP  = 4'd9;
    localparam logic [3:0]            C_ADDR_EN    = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t                r_state;
    logic [RESOLUTION-1:0] r_cnt;
    logic [RESOLUTION-1:0] r_step;
    logic                  r_enable;
    logic [3:0]            r_ch;
    logic [RESOLUTION-1:0] r_target [C_NCH];
    logic [RESOLUTION-1:0] r_duty   [C_NCH];
    logic [RESOLUTION-1:0] r_next   [C_NCH];

    logic [RESOLUTION-1:0] w_eff;
    logic [RESOLUTION-1:0] w_cur;
    logic [RESOLUTION-1:0] w_next;
    logic                  w_mismatch;
    logic                  w_wr_fire;

    assign w_wr_fire = wr_valid && wr_ready;
    assign w_cur     = r_duty[r_ch];
    assign w_eff     = r_enable ? r_target[r_ch] : '0;

    // Ramp result is always clamped to eff, so the add/subtract cannot wrap.
    always_comb begin
        w_next = w_eff;
        if ((r_step != '0) && r_enable) begin
            if (w_eff > w_cur)
                w_next = ((w_eff - w_cur) > r_step) ? (w_cur + r_step) : w_eff;
            else if (w_eff < w_cur)
                w_next = ((w_cur - w_eff) > r_step) ? (w_cur - r_step) : w_eff;
            else
                w_next = w_cur;
        end
    end

    always_comb begin
        w_mismatch = 1'b0;
        for (int n = 0; n < C_NCH; n++) begin
            if (r_next[n] != (r_enable ? r_target[n] : '0))
                w_mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_step      <= '0;
            r_enable    <= 1'b0;
            r_ch        <= '0;
            wr_ready    <= 1'b1;
            period_tick <= 1'b0;
            busy        <= 1'b0;
            for (int n = 0; n < C_NCH; n++) begin
                r_target[n] <= '0;
                r_duty[n]   <= '0;
                r_next[n]   <= '0;
            end
        end else begin
            r_cnt       <= r_cnt + RESOLUTION'(1);
            period_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_fire) begin
                        if (wr_addr <= C_LAST_CH)
                            r_target[wr_addr] <= wr_data;
                        else if (wr_addr == C_ADDR_STEP)
                            r_step <= wr_data;
                        else if (wr_addr == C_ADDR_EN)
                            r_enable <= wr_data[0];
                    end
                    if (r_cnt == C_CALC_ENTRY) begin
                        r_state  <= ST_CALC;
                        r_ch     <= '0;
                        wr_ready <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r_next[r_ch] <= w_next;
                    r_ch         <= r_ch + 4'd1;
                    if (r_ch == C_LAST_CH)
                        r_state <= ST_APPLY;
                end
                ST_APPLY: begin
                    // Counter is at MAX here, so this edge is the period wrap.
                    for (int n = 0; n < C_NCH; n++)
                        r_duty[n] <= r_next[n];
                    period_tick <= 1'b1;
                    busy        <= w_mismatch;
                    wr_ready    <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign duty0 = r_duty[0];
    assign duty1 = r_duty[1];
    assign duty2 = r_duty[2];
    assign duty3 = r_duty[3];
    assign duty4 = r_duty[4];
    assign duty5 = r_duty[5];
    assign duty6 = r_duty[6];
    assign duty7 = r_duty[7];
    assign duty8 = r_duty[8];

endmodule

`default_nettype wire
